// File: rtl/panda_icb_arbiter.sv
// Round-robin ICB arbiter: MST_N masters share one slave port; an in-order
// outstanding-ID FIFO steers each slave response back to its issuing master.
module panda_icb_arbiter #(
   parameter int MST_N     = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int OST_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [MST_N*ADDR_W-1:0]    m_cmd_addr_i,
   input  logic [MST_N-1:0]           m_cmd_read_i,
   input  logic [MST_N*DATA_W-1:0]    m_cmd_wdata_i,
   input  logic [MST_N*DATA_W/8-1:0]  m_cmd_wmask_i,
   input  logic [MST_N-1:0]           m_cmd_valid_i,
   output logic [MST_N-1:0]           m_cmd_ready_o,
   output logic [DATA_W-1:0]          m_rsp_rdata_o,
   output logic                       m_rsp_err_o,
   output logic [MST_N-1:0]           m_rsp_valid_o,
   input  logic [MST_N-1:0]           m_rsp_ready_i,
   output logic [ADDR_W-1:0]          s_cmd_addr_o,
   output logic                       s_cmd_read_o,
   output logic [DATA_W-1:0]          s_cmd_wdata_o,
   output logic [DATA_W/8-1:0]        s_cmd_wmask_o,
   output logic                       s_cmd_valid_o,
   input  logic                       s_cmd_ready_i,
   input  logic [DATA_W-1:0]          s_rsp_rdata_i,
   input  logic                       s_rsp_err_i,
   input  logic                       s_rsp_valid_i,
   output logic                       s_rsp_ready_o
);

   localparam int ID_W  = $clog2(MST_N);
   localparam int PTR_W = $clog2(OST_DEPTH);
   localparam int CNT_W = $clog2(OST_DEPTH) + 1;
   localparam int MSK_W = DATA_W / 8;

   logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
   logic             lock_vld_q, lock_vld_d;
   logic [ID_W-1:0]  lock_id_q, lock_id_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
   logic [ID_W-1:0]  fifo_q [OST_DEPTH];

   logic             full_s;
   logic             grant_vld_s;
   logic [ID_W-1:0]  grant_id_s;
   logic [ID_W-1:0]  head_id_s;
   logic             push_s;
   logic             pop_s;

   assign full_s    = (count_q == CNT_W'(OST_DEPTH));
   assign head_id_s = fifo_q[rd_ptr_q];
   assign push_s    = s_cmd_valid_o && s_cmd_ready_i;
   assign pop_s     = s_rsp_valid_i && s_rsp_ready_o;

   // Winner selection; gated by rst_n so nothing is offered while in reset.
   always_comb begin
      logic [ID_W-1:0] idx;
      idx         = '0;
      grant_vld_s = 1'b0;
      grant_id_s  = '0;
      if (lock_vld_q) begin
         grant_vld_s = 1'b1;
         grant_id_s  = lock_id_q;
      end else if (rst_n && !full_s) begin
         for (int k = 0; k < MST_N; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % MST_N);
            if (!grant_vld_s && m_cmd_valid_i[idx]) begin
               grant_vld_s = 1'b1;
               grant_id_s  = idx;
            end
         end
      end else begin
         grant_vld_s = 1'b0;
      end
   end

   // Command payload mux and per-master ready.
   always_comb begin
      s_cmd_addr_o  = m_cmd_addr_i[ADDR_W-1:0];
      s_cmd_read_o  = m_cmd_read_i[0];
      s_cmd_wdata_o = m_cmd_wdata_i[DATA_W-1:0];
      s_cmd_wmask_o = m_cmd_wmask_i[MSK_W-1:0];
      s_cmd_valid_o = grant_vld_s;
      m_cmd_ready_o = '0;
      for (int i = 0; i < MST_N; i++) begin
         if (grant_id_s == ID_W'(i)) begin
            s_cmd_addr_o  = m_cmd_addr_i[i*ADDR_W +: ADDR_W];
            s_cmd_read_o  = m_cmd_read_i[i];
            s_cmd_wdata_o = m_cmd_wdata_i[i*DATA_W +: DATA_W];
            s_cmd_wmask_o = m_cmd_wmask_i[i*MSK_W +: MSK_W];
            m_cmd_ready_o[i] = grant_vld_s && s_cmd_ready_i;
         end else begin
            m_cmd_ready_o[i] = 1'b0;
         end
      end
   end

   // Response steering to the master at the FIFO head; empty FIFO stalls the slave.
   always_comb begin
      m_rsp_rdata_o = s_rsp_rdata_i;
      m_rsp_err_o   = s_rsp_err_i;
      m_rsp_valid_o = '0;
      s_rsp_ready_o = 1'b0;
      if (count_q != '0) begin
         for (int i = 0; i < MST_N; i++) begin
            if (head_id_s == ID_W'(i)) begin
               m_rsp_valid_o[i] = s_rsp_valid_i;
               s_rsp_ready_o    = m_rsp_ready_i[i];
            end else begin
               m_rsp_valid_o[i] = 1'b0;
            end
         end
      end else begin
         s_rsp_ready_o = 1'b0;
      end
   end

   // Next-state for round-robin pointer, lock and FIFO bookkeeping.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push_s) begin
         rr_ptr_d   = (grant_id_s == ID_W'(MST_N - 1)) ? '0 : grant_id_s + ID_W'(1);
         lock_vld_d = 1'b0;
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end else if (s_cmd_valid_o) begin
         lock_vld_d = 1'b1;
         lock_id_d  = grant_id_s;
      end else begin
         lock_vld_d = lock_vld_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers and FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         lock_vld_q <= 1'b0;
         lock_id_q  <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < OST_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (push_s) begin
            fifo_q[wr_ptr_q] <= grant_id_s;
         end
      end
   end

endmodule

// File: tb/tb_panda_icb_arbiter.sv
// Directed bench for panda_icb_arbiter (MST_N=2, OST_DEPTH=4): a vector table for
// grant/response routing plus hand sequences for backpressure, full stall and reset.
module tb_panda_icb_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [63:0]   m_cmd_addr;
   logic [1:0]    m_cmd_read;
   logic [63:0]   m_cmd_wdata;
   logic [7:0]    m_cmd_wmask;
   logic [1:0]    m_cmd_valid;
   logic [1:0]    m_cmd_ready;
   logic [31:0]   m_rsp_rdata;
   logic          m_rsp_err;
   logic [1:0]    m_rsp_valid;
   logic [1:0]    m_rsp_ready;
   logic [31:0]   s_cmd_addr;
   logic          s_cmd_read;
   logic [31:0]   s_cmd_wdata;
   logic [3:0]    s_cmd_wmask;
   logic          s_cmd_valid;
   logic          s_cmd_ready;
   logic [31:0]   s_rsp_rdata;
   logic          s_rsp_err;
   logic          s_rsp_valid;
   logic          s_rsp_ready;

   int checks = 0;
   int errors = 0;

   panda_icb_arbiter #(.MST_N(2), .ADDR_W(32), .DATA_W(32), .OST_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_cmd_addr_i(m_cmd_addr), .m_cmd_read_i(m_cmd_read),
      .m_cmd_wdata_i(m_cmd_wdata), .m_cmd_wmask_i(m_cmd_wmask),
      .m_cmd_valid_i(m_cmd_valid), .m_cmd_ready_o(m_cmd_ready),
      .m_rsp_rdata_o(m_rsp_rdata), .m_rsp_err_o(m_rsp_err),
      .m_rsp_valid_o(m_rsp_valid), .m_rsp_ready_i(m_rsp_ready),
      .s_cmd_addr_o(s_cmd_addr), .s_cmd_read_o(s_cmd_read),
      .s_cmd_wdata_o(s_cmd_wdata), .s_cmd_wmask_o(s_cmd_wmask),
      .s_cmd_valid_o(s_cmd_valid), .s_cmd_ready_i(s_cmd_ready),
      .s_rsp_rdata_i(s_rsp_rdata), .s_rsp_err_i(s_rsp_err),
      .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(s_rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  mv;
      logic [31:0] a0;
      logic [31:0] a1;
      logic        sr;
      logic        rv;
      logic [1:0]  rr;
      logic        e_sv;
      logic [31:0] e_addr;
      logic [1:0]  e_mr;
      logic [1:0]  e_rv;
      logic        e_srr;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string nm, input logic [1:0] e_rv, input logic e_srr);
      chk({nm, "_mrspv"}, 32'(m_rsp_valid), 32'(e_rv));
      chk({nm, "_srspr"}, 32'(s_rsp_ready), 32'(e_srr));
   endtask

   task automatic chk_cmd(input string nm, input logic e_sv, input logic [1:0] e_mr);
      chk({nm, "_svalid"}, 32'(s_cmd_valid), 32'(e_sv));
      chk({nm, "_mready"}, 32'(m_cmd_ready), 32'(e_mr));
   endtask

   initial begin
      // mv, a0, a1, sr, rv, rr | sv, addr, mready, mrspv, srspready
      vt[0]  = '{2'b10, 32'h0,   32'h100, 1'b1, 1'b0, 2'b00, 1'b1, 32'h100, 2'b10, 2'b00, 1'b0};
      vt[1]  = '{2'b11, 32'h10,  32'h20,  1'b1, 1'b0, 2'b11, 1'b1, 32'h10,  2'b01, 2'b00, 1'b1};
      vt[2]  = '{2'b11, 32'h10,  32'h20,  1'b1, 1'b0, 2'b11, 1'b1, 32'h20,  2'b10, 2'b00, 1'b1};
      vt[3]  = '{2'b11, 32'h10,  32'h20,  1'b1, 1'b1, 2'b11, 1'b1, 32'h10,  2'b01, 2'b10, 1'b1};
      vt[4]  = '{2'b00, 32'h10,  32'h20,  1'b1, 1'b1, 2'b11, 1'b0, 32'h10,  2'b00, 2'b01, 1'b1};
      vt[5]  = '{2'b00, 32'h10,  32'h20,  1'b1, 1'b1, 2'b11, 1'b0, 32'h10,  2'b00, 2'b10, 1'b1};
      vt[6]  = '{2'b00, 32'h10,  32'h20,  1'b1, 1'b1, 2'b11, 1'b0, 32'h10,  2'b00, 2'b01, 1'b1};
      vt[7]  = '{2'b00, 32'h10,  32'h20,  1'b1, 1'b1, 2'b11, 1'b0, 32'h10,  2'b00, 2'b00, 1'b0};
      vt[8]  = '{2'b10, 32'h300, 32'h200, 1'b0, 1'b0, 2'b00, 1'b1, 32'h200, 2'b00, 2'b00, 1'b0};
      vt[9]  = '{2'b11, 32'h300, 32'h200, 1'b0, 1'b0, 2'b00, 1'b1, 32'h200, 2'b00, 2'b00, 1'b0};
      vt[10] = '{2'b11, 32'h300, 32'h200, 1'b0, 1'b0, 2'b00, 1'b1, 32'h200, 2'b00, 2'b00, 1'b0};
      vt[11] = '{2'b11, 32'h300, 32'h200, 1'b1, 1'b0, 2'b00, 1'b1, 32'h200, 2'b10, 2'b00, 1'b0};
      vt[12] = '{2'b01, 32'h300, 32'h200, 1'b1, 1'b0, 2'b00, 1'b1, 32'h300, 2'b01, 2'b00, 1'b0};

      rst_n       = 1'b0;
      m_cmd_addr  = {$urandom, $urandom};
      m_cmd_read  = 2'($urandom);
      m_cmd_wdata = {$urandom, $urandom};
      m_cmd_wmask = 8'($urandom);
      m_cmd_valid = 2'b11;
      m_rsp_ready = 2'b11;
      s_cmd_ready = 1'b1;
      s_rsp_rdata = $urandom;
      s_rsp_err   = 1'b1;
      s_rsp_valid = 1'b1;
      #2;
      chk_cmd("reset", 1'b0, 2'b00);
      chk_rsp("reset", 2'b00, 1'b0);
      tick();
      tick();
      m_cmd_read  = 2'b10;
      m_cmd_wmask = 8'hFF;
      s_rsp_rdata = 32'h0;
      s_rsp_err   = 1'b0;
      rst_n       = 1'b1;

      for (int v = 0; v < 13; v++) begin
         m_cmd_valid = vt[v].mv;
         m_cmd_addr  = {vt[v].a1, vt[v].a0};
         s_cmd_ready = vt[v].sr;
         s_rsp_valid = vt[v].rv;
         m_rsp_ready = vt[v].rr;
         #1;
         chk($sformatf("v%0d_svalid", v), 32'(s_cmd_valid), 32'(vt[v].e_sv));
         chk($sformatf("v%0d_saddr", v), s_cmd_addr, vt[v].e_addr);
         chk($sformatf("v%0d_mready", v), 32'(m_cmd_ready), 32'(vt[v].e_mr));
         chk($sformatf("v%0d_mrspv", v), 32'(m_rsp_valid), 32'(vt[v].e_rv));
         chk($sformatf("v%0d_srspr", v), 32'(s_rsp_ready), 32'(vt[v].e_srr));
         tick();
      end

      // Response backpressure: head becomes master 0 after one pop.
      m_cmd_valid = 2'b00;
      s_rsp_valid = 1'b1;
      m_rsp_ready = 2'b10;
      #1;
      chk_rsp("bp_pre", 2'b10, 1'b1);
      tick();
      s_rsp_rdata = 32'hDEADBEEF;
      s_rsp_err   = 1'b1;
      m_rsp_ready = 2'b00;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk_rsp("bp_hold", 2'b01, 1'b0);
         chk("bp_rdata", m_rsp_rdata, 32'hDEADBEEF);
         chk("bp_err", 32'(m_rsp_err), 32'h1);
         tick();
      end
      m_rsp_ready = 2'b01;
      #1;
      chk_rsp("bp_pop", 2'b01, 1'b1);
      tick();
      m_rsp_ready = 2'b11;
      #1;
      chk_rsp("bp_empty", 2'b00, 1'b0);
      s_rsp_valid = 1'b0;
      s_rsp_err   = 1'b0;

      // Full stall: four accepts, fifth blocked until a pop, then granted.
      m_cmd_valid = 2'b01;
      m_cmd_addr  = {32'h0, 32'h400};
      s_cmd_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk_cmd($sformatf("full_acc%0d", c), 1'b1, 2'b01);
         tick();
      end
      s_rsp_valid = 1'b1;
      m_rsp_ready = 2'b01;
      #1;
      chk_cmd("full_stall", 1'b0, 2'b00);
      chk_rsp("full_pop", 2'b01, 1'b1);
      tick();
      s_rsp_valid = 1'b0;
      #1;
      chk_cmd("full_resume", 1'b1, 2'b01);
      tick();
      #1;
      chk_cmd("full_again", 1'b0, 2'b00);

      // Drain two, then reset with two outstanding.
      m_cmd_valid = 2'b00;
      s_rsp_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk_rsp("drain", 2'b01, 1'b1);
         tick();
      end
      m_rsp_ready = 2'b11;
      rst_n = 1'b0;
      #1;
      chk_rsp("mid_rst", 2'b00, 1'b0);
      #1;
      rst_n = 1'b1;
      #1;
      chk_rsp("post_rst", 2'b00, 1'b0);
      tick();
      chk_rsp("post_rst_cyc", 2'b00, 1'b0);
      s_rsp_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/panda_icb_arbiter.md
Name: panda_icb_arbiter

Overview:
- Shares one ICB slave port among MST_N ICB masters using round-robin arbitration on the command channel.
- Records the issuing master of every accepted command in an in-order outstanding-ID FIFO, and routes each response back to that master.
- Sits between DMA/control masters and a shared register or memory ICB slave. Used by the panda VIP benches as the DUT for the ICB master/slave agents.

Parameters:
MST_N, 2, number of masters (2..8)
ADDR_W, 32, command address width
DATA_W, 32, data width (multiple of 8)
OST_DEPTH, 4, max outstanding commands (power of 2, >=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
m_cmd_addr  input  MST_N*ADDR_W  per-master address, master i at slice [i*ADDR_W +: ADDR_W]
m_cmd_read  input  MST_N  per-master read flag
m_cmd_wdata  input  MST_N*DATA_W  per-master write data
m_cmd_wmask  input  MST_N*DATA_W/8  per-master byte mask
m_cmd_valid  input  MST_N  per-master command valid
m_cmd_ready  output  MST_N  per-master command ready
m_rsp_rdata  output  DATA_W  response data, broadcast to all masters
m_rsp_err  output  1  response error, broadcast to all masters
m_rsp_valid  output  MST_N  per-master response valid
m_rsp_ready  input  MST_N  per-master response ready
s_cmd_addr  output  ADDR_W  slave address
s_cmd_read  output  1  slave read flag
s_cmd_wdata  output  DATA_W  slave write data
s_cmd_wmask  output  DATA_W/8  slave byte mask
s_cmd_valid  output  1  slave command valid
s_cmd_ready  input  1  slave command ready
s_rsp_rdata  input  DATA_W  slave response data
s_rsp_err  input  1  slave response error
s_rsp_valid  input  1  slave response valid
s_rsp_ready  output  1  slave response ready

Behaviour:
- State at reset:
  - rr_ptr=0, fifo count=0, rd/wr pointers=0, lock_vld=0, lock_id=0.
  - All outputs resolve to 0: s_cmd_valid, m_cmd_ready, m_rsp_valid, s_rsp_ready. Payload outputs = master 0 slice / s_rsp values.
- Arbitration (combinational, zero latency):
  - When lock_vld=0 and the FIFO is not full, the winner is the first i with m_cmd_valid[i]=1, searching from rr_ptr upward modulo MST_N.
  - When lock_vld=1, the winner is lock_id.
- Command channel:
  - s_cmd_* carries the winner's payload.
  - s_cmd_valid = winner exists.
  - m_cmd_ready[winner] = s_cmd_ready; all other bits are 0.
- Lock:
  - Set when s_cmd_valid=1 && s_cmd_ready=0, with lock_id=winner.
  - Cleared on the handshake. A command presented to the slave is never withdrawn or switched.
- Accept (s_cmd_valid && s_cmd_ready):
  - Push winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod MST_N.
  - lock_vld <= 0.
- FIFO full (count==OST_DEPTH):
  - No new grant: s_cmd_valid=0 and all m_cmd_ready=0.
  - A locked command cannot exist at full, because the lock is only set while not full.
  - A pop in the same cycle does not unblock; the grant resumes the next cycle.
- Response routing:
  - head = FIFO[rd_ptr].
  - When count>0: m_rsp_valid[head] = s_rsp_valid, and s_rsp_ready = m_rsp_ready[head].
  - When count==0: s_rsp_ready=0 and all m_rsp_valid=0. A stray slave response is stalled, not dropped.
  - Pop on s_rsp_valid && s_rsp_ready.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers: wrap modulo OST_DEPTH. count width is clog2(OST_DEPTH)+1.
- Master protocol: masters must hold m_cmd_valid and payload until ready. Deasserting valid while locked is a protocol violation; the arbiter still holds lock_id.
- Reset mid-transaction: all in-flight state is discarded immediately. Responses arriving after reset deassertion are stalled (FIFO empty).

Test Plan:
- Reset: rst_n=0 with random inputs -> s_cmd_valid=0, m_cmd_ready=0, s_rsp_ready=0, m_rsp_valid=0. After release, master 1 alone requests addr 0x100 read -> s_cmd_addr=0x100 in the same cycle.
- Round-robin:
  - Setup: masters 0 and 1 both valid continuously, slave always ready.
  - Expected: grants alternate 0,1,0,1. FIFO IDs pop in the same order, each response appears only on the matching m_rsp_valid bit.
- Lock:
  - Setup: master 1 granted while s_cmd_ready=0 for 3 cycles, master 0 raising valid in cycle 2.
  - Expected: s_cmd_addr stays master 1's (0x200) until the handshake; master 0 is granted next.
- Full stall:
  - Setup: OST_DEPTH=4, slave never responds, 5 commands issued.
  - Expected: 4 accepted, then s_cmd_valid=0.
  - Follow-up: one response popped -> 5th command is accepted one cycle later.
- Backpressure:
  - Setup: head ID=0, s_rsp_valid=1, m_rsp_ready[0]=0 for 2 cycles, rdata=0xDEADBEEF, err=1.
  - Expected: s_rsp_ready=0 for those 2 cycles, with m_rsp_rdata=0xDEADBEEF and m_rsp_err=1 held. Pop occurs on the cycle m_rsp_ready[0]=1.
- Mid-operation reset: 2 commands outstanding, then rst_n pulsed -> count=0. A subsequent s_rsp_valid=1 yields s_rsp_ready=0 and no m_rsp_valid.
